// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, ALU op encodings, instruction field
// positions and the fetch/execute state encoding.
package cpu_defs_pkg;

    // Opcodes (values 8..255 are undefined)
    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;

    // ALU operation select
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Instruction fields: OP[31:24] DEST[23:16] SRC1[15:8] SRC2/IMM[7:0]
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: IR -> register addresses,
// immediate, ALU controls and instruction class flags.
module instr_decoder
    import cpu_defs_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [31:0]       ir_i,
    output logic [REG_AW-1:0] rr1_o,
    output logic [REG_AW-1:0] rr2_o,
    output logic [REG_AW-1:0] wr_o,
    output logic [7:0]        imm_o,
    output logic [2:0]        aluop_o,
    output logic              imm_sel_o,
    output logic              neg_sel_o,
    output logic              wr_class_o,
    output logic              jump_o,
    output logic              beq_o,
    output logic              ill_o
);

    logic [7:0] op;
    logic       unused_ir_bits;

    assign op    = ir_i[OP_MSB:OP_LSB];
    assign rr1_o = ir_i[SRC1_LSB +: REG_AW];
    assign rr2_o = ir_i[SRC2_LSB +: REG_AW];
    assign wr_o  = ir_i[DEST_LSB +: REG_AW];
    assign imm_o = ir_i[SRC2_MSB:SRC2_LSB];
    // Upper register-field bits are don't-care for the register file
    assign unused_ir_bits = ^ir_i;

    // Opcode -> ALU controls and instruction class
    always_comb begin
        aluop_o    = ALU_FWD;
        imm_sel_o  = 1'b0;
        neg_sel_o  = 1'b0;
        wr_class_o = 1'b0;
        jump_o     = 1'b0;
        beq_o      = 1'b0;
        ill_o      = 1'b0;
        case (op)
            OP_LOADI: begin wr_class_o = 1'b1; imm_sel_o = 1'b1; end
            OP_MOV:   begin wr_class_o = 1'b1; end
            OP_ADD:   begin wr_class_o = 1'b1; aluop_o = ALU_ADD; end
            OP_SUB:   begin wr_class_o = 1'b1; aluop_o = ALU_ADD; neg_sel_o = 1'b1; end
            OP_AND:   begin wr_class_o = 1'b1; aluop_o = ALU_AND; end
            OP_OR:    begin wr_class_o = 1'b1; aluop_o = ALU_OR; end
            OP_J:     begin jump_o = 1'b1; end
            OP_BEQ:   begin beq_o = 1'b1; aluop_o = ALU_ADD; neg_sel_o = 1'b1; end
            default:  begin ill_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Front-end control stage: owns PC and IR, fetches through a busywait
// handshake, decodes IR for the register file/ALU and resolves j/beq.
module instr_fetch_decode
    import cpu_defs_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  REG_AW   = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         IMEM_DATA,
    input  logic                IMEM_BUSYWAIT,
    input  logic                ZERO,
    output logic                IMEM_READ,
    output logic [PC_WIDTH-1:0] IMEM_ADDR,
    output logic [REG_AW-1:0]   READREG1,
    output logic [REG_AW-1:0]   READREG2,
    output logic [REG_AW-1:0]   WRITEREG,
    output logic                WRITEENABLE,
    output logic [7:0]          IMMEDIATE,
    output logic [2:0]          ALUOP,
    output logic                IMM_SEL,
    output logic                NEG_SEL,
    output logic                ILLEGAL
);

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q;
    logic                rd_q;

    logic [REG_AW-1:0]   rr1, rr2, wr;
    logic [7:0]          imm;
    logic [2:0]          aluop;
    logic                imm_sel, neg_sel, wr_class, jump, beq, ill;
    logic [PC_WIDTH-1:0] pc_plus4, br_sext, br_off;

    instr_decoder #(.REG_AW(REG_AW)) u_dec (
        .ir_i       (ir_q),
        .rr1_o      (rr1),
        .rr2_o      (rr2),
        .wr_o       (wr),
        .imm_o      (imm),
        .aluop_o    (aluop),
        .imm_sel_o  (imm_sel),
        .neg_sel_o  (neg_sel),
        .wr_class_o (wr_class),
        .jump_o     (jump),
        .beq_o      (beq),
        .ill_o      (ill)
    );

    // Branch target: DEST is a signed word offset relative to PC+4
    assign pc_plus4 = pc_q + PC_WIDTH'(4);
    assign br_sext  = PC_WIDTH'($signed(ir_q[DEST_MSB:DEST_LSB]));
    assign br_off   = {br_sext[PC_WIDTH-3:0], 2'b00};

    // Next PC, consumed only at the edge that closes EXEC
    always_comb begin
        pc_d = pc_plus4;
        if (jump || (beq && ZERO)) pc_d = pc_plus4 + br_off;
    end

    // Fetch/execute FSM with PC, IR and registered fetch request.
    // rd_q stays low for the first cycle out of reset so IR only loads
    // once a request has actually been presented to memory.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            rd_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (rd_q && !IMEM_BUSYWAIT) begin
                        ir_q    <= IMEM_DATA;
                        state_q <= ST_EXEC;
                        rd_q    <= 1'b0;
                    end else begin
                        rd_q    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    pc_q    <= pc_d;
                    state_q <= ST_FETCH;
                    rd_q    <= 1'b1;
                end
                default: begin
                    state_q <= ST_FETCH;
                    rd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_READ = rd_q;
    assign IMEM_ADDR = pc_q;

    // Decode outputs forced to zero while reset is held (IR=0 would
    // otherwise decode as loadi)
    assign READREG1    = RESET ? rr1     : '0;
    assign READREG2    = RESET ? rr2     : '0;
    assign WRITEREG    = RESET ? wr      : '0;
    assign IMMEDIATE   = RESET ? imm     : '0;
    assign ALUOP       = RESET ? aluop   : '0;
    assign IMM_SEL     = RESET && imm_sel;
    assign NEG_SEL     = RESET && neg_sel;
    assign WRITEENABLE = RESET && (state_q == ST_EXEC) && wr_class;
    assign ILLEGAL     = RESET && (state_q == ST_EXEC) && ill;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: instruction-level model plus
// directed vectors with literal expectations. A second instance with
// RESET_PC=0xFFFFFFFC shares all inputs to exercise PC wrap-around.
module tb_instr_fetch_decode;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] data = 32'h0;
    logic        busy = 1'b1;
    logic        zero = 1'b0;

    logic        rd1, we1, immsel1, negsel1, ill1;
    logic [31:0] addr1;
    logic [2:0]  rr1a, rr2a, wra, aluop1;
    logic [7:0]  imm1;
    logic        rd2, we2, immsel2, negsel2, ill2;
    logic [31:0] addr2;
    logic [2:0]  rr1b, rr2b, wrb, aluop2;
    logic [7:0]  imm2;

    int checks = 0;
    int failures = 0;

    instr_fetch_decode u_dut (
        .CLK(CLK), .RESET(RESET), .IMEM_DATA(data), .IMEM_BUSYWAIT(busy), .ZERO(zero),
        .IMEM_READ(rd1), .IMEM_ADDR(addr1), .READREG1(rr1a), .READREG2(rr2a),
        .WRITEREG(wra), .WRITEENABLE(we1), .IMMEDIATE(imm1), .ALUOP(aluop1),
        .IMM_SEL(immsel1), .NEG_SEL(negsel1), .ILLEGAL(ill1)
    );

    instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(CLK), .RESET(RESET), .IMEM_DATA(data), .IMEM_BUSYWAIT(busy), .ZERO(zero),
        .IMEM_READ(rd2), .IMEM_ADDR(addr2), .READREG1(rr1b), .READREG2(rr2b),
        .WRITEREG(wrb), .WRITEENABLE(we2), .IMMEDIATE(imm2), .ALUOP(aluop2),
        .IMM_SEL(immsel2), .NEG_SEL(negsel2), .ILLEGAL(ill2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_rd: a fetch request is outstanding; m_exec: the instruction in m_ir
    // is executing this cycle.
    logic [31:0] m_pc, m_ir;
    logic        m_rd, m_exec;

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                               input logic z);
        int off;
        off = int'($signed(ir[23:16]));
        if (ir[31:24] == 8'd6 || (ir[31:24] == 8'd7 && z)) return pc + 32'(4 + off * 4);
        return pc + 32'd4;
    endfunction

    function automatic logic [2:0] model_aluop(input logic [7:0] op);
        case (op)
            8'd2, 8'd3, 8'd7: return 3'b001;
            8'd4:             return 3'b010;
            8'd5:             return 3'b011;
            default:          return 3'b000;
        endcase
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_pc <= 32'h0; m_ir <= 32'h0; m_rd <= 1'b0; m_exec <= 1'b0;
        end else if (m_exec) begin
            m_pc <= model_next(m_pc, m_ir, zero);
            m_exec <= 1'b0; m_rd <= 1'b1;
        end else if (m_rd && !busy) begin
            m_ir <= data; m_exec <= 1'b1; m_rd <= 1'b0;
        end else begin
            m_rd <= 1'b1;
        end
    end

    // Compare every cycle, on the inactive edge
    always @(negedge CLK) begin
        logic [7:0] op;
        logic       g;
        op = m_ir[31:24];
        g  = RESET;
        chk("imem_read", 32'(rd1), 32'(m_rd));
        chk("imem_addr", addr1, m_pc);
        chk("wrap_addr", addr2, m_pc - 32'd4);
        chk("readreg1", 32'(rr1a), g ? 32'(m_ir[10:8]) : 32'd0);
        chk("readreg2", 32'(rr2a), g ? 32'(m_ir[2:0]) : 32'd0);
        chk("writereg", 32'(wra), g ? 32'(m_ir[18:16]) : 32'd0);
        chk("immediate", 32'(imm1), g ? 32'(m_ir[7:0]) : 32'd0);
        chk("aluop", 32'(aluop1), g ? 32'(model_aluop(op)) : 32'd0);
        chk("imm_sel", 32'(immsel1), 32'(g && op == 8'd0));
        chk("neg_sel", 32'(negsel1), 32'(g && (op == 8'd3 || op == 8'd7)));
        chk("writeenable", 32'(we1), 32'(g && m_exec && op < 8'd6));
        chk("illegal", 32'(ill1), 32'(g && m_exec && op > 8'd7));
        chk("wrap_we", 32'(we2), 32'(g && m_exec && op < 8'd6));
        chk("wrap_ill", 32'(ill2), 32'(g && m_exec && op > 8'd7));
    end

    // ---------------- directed stimulus ----------------
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Present an instruction with 'waits' busy cycles; returns in EXEC.
    task automatic issue(input logic [31:0] d, input int waits, input logic z);
        data = d; zero = z; busy = 1'b1;
        repeat (waits) step;
        busy = 1'b0;
        step;
        busy = 1'b1;
    endtask

    initial begin
        // reset held 3 cycles
        repeat (3) begin
            step;
            chk("rst_we", 32'(we1), 32'd0);
            chk("rst_read", 32'(rd1), 32'd0);
            chk("rst_immsel", 32'(immsel1), 32'd0);
        end
        RESET = 1'b1;
        step;
        chk("post_rst_read", 32'(rd1), 32'd1);
        chk("post_rst_addr", addr1, 32'h0);

        // loadi r3,56 with 3 busy cycles
        issue(32'h0003_0038, 3, 1'b0);
        chk("ld_wr", 32'(wra), 32'd3);
        chk("ld_imm", 32'(imm1), 32'd56);
        chk("ld_immsel", 32'(immsel1), 32'd1);
        chk("ld_we", 32'(we1), 32'd1);
        chk("ld_read", 32'(rd1), 32'd0);
        step;
        chk("ld_we_off", 32'(we1), 32'd0);
        chk("ld_next", addr1, 32'h4);

        // sub r1,r2,r5
        issue(32'h0301_0205, 0, 1'b0);
        chk("sub_rr1", 32'(rr1a), 32'd2);
        chk("sub_rr2", 32'(rr2a), 32'd5);
        chk("sub_wr", 32'(wra), 32'd1);
        chk("sub_aluop", 32'(aluop1), 32'd1);
        chk("sub_neg", 32'(negsel1), 32'd1);
        step;
        chk("sub_next", addr1, 32'h8);

        issue(32'h0402_0304, 1, 1'b0);
        chk("and_aluop", 32'(aluop1), 32'd2);
        step;
        issue(32'h0503_0406, 0, 1'b0);
        chk("or_aluop", 32'(aluop1), 32'd3);
        step;
        chk("pc_10", addr1, 32'h10);

        // beq taken backwards
        issue(32'h07FE_0102, 0, 1'b1);
        chk("beq_we", 32'(we1), 32'd0);
        chk("beq_neg", 32'(negsel1), 32'd1);
        step;
        chk("beq_taken", addr1, 32'h0C);
        issue(32'h0102_0300, 0, 1'b0);
        step;
        issue(32'h07FE_0102, 0, 1'b0);
        step;
        chk("beq_not_taken", addr1, 32'h14);

        // illegal opcodes (top and bottom of the undefined range)
        issue(32'hFF00_0000, 0, 1'b0);
        chk("ill_pulse", 32'(ill1), 32'd1);
        chk("ill_we", 32'(we1), 32'd0);
        step;
        chk("ill_off", 32'(ill1), 32'd0);
        chk("ill_next", addr1, 32'h18);
        issue(32'h0800_0000, 0, 1'b0);
        chk("ill8_pulse", 32'(ill1), 32'd1);
        step;
        issue(32'h0701_0000, 2, 1'b1);
        step;
        chk("beq_fwd", addr1, 32'h24);

        // reset asserted mid-fetch
        step;
        RESET = 1'b0;
        #1;
        chk("midrst_read", 32'(rd1), 32'd0);
        chk("midrst_addr", addr1, 32'h0);
        chk("midrst_wrap", addr2, 32'hFFFF_FFFC);
        repeat (3) step;
        RESET = 1'b1;
        step;

        // j +0x7F from PC=0
        issue(32'h067F_0000, 0, 1'b0);
        chk("j_we", 32'(we1), 32'd0);
        chk("j_ill", 32'(ill1), 32'd0);
        step;
        chk("j_target", addr1, 32'h200);
        chk("j_wrap_inst", addr2, 32'h1FC);

        // wrap: add from 0xFFFFFFFC lands at 0
        RESET = 1'b0;
        repeat (3) step;
        RESET = 1'b1;
        step;
        issue(32'h0201_0203, 0, 1'b0);
        chk("add_we", 32'(we2), 32'd1);
        step;
        chk("wrap_zero", addr2, 32'h0);
        chk("wrap_main", addr1, 32'h4);
        repeat (3) step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front-end control stage of the 8-register CPU. Sits directly upstream of the 8x8 register file.
- Owns the PC and fetches 32-bit instructions from instruction memory through a busywait handshake.
- Latches each instruction into an IR and decodes it into register-file read/write addresses, a one-cycle write enable, the immediate, and ALU controls.
- Resolves j/beq itself, using the ALU ZERO flag.

Parameters:
PC_WIDTH, 32, width of PC and IMEM_ADDR
RESET_PC, 0, PC value loaded on reset
REG_AW, 3, register-file address width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous active-low reset (0 = reset)
IMEM_DATA  in  32  instruction word from memory
IMEM_BUSYWAIT  in  1  memory busy; data valid on a cycle where IMEM_READ=1 and BUSYWAIT=0
ZERO  in  1  ALU result==0, valid during EXEC
IMEM_READ  out  1  fetch request
IMEM_ADDR  out  PC_WIDTH  current PC
READREG1  out  REG_AW  source-1 register (to reg file)
READREG2  out  REG_AW  source-2 register (to reg file)
WRITEREG  out  REG_AW  destination register (to reg file)
WRITEENABLE  out  1  reg-file write strobe
IMMEDIATE  out  8  immediate operand
ALUOP  out  3  000 fwd, 001 add, 010 and, 011 or
IMM_SEL  out  1  1 = ALU operand 2 from IMMEDIATE
NEG_SEL  out  1  1 = negate operand 2 (sub, beq)
ILLEGAL  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset
  - RESET=0 asynchronously forces: PC=RESET_PC, IR=0, state=FETCH, ILLEGAL=0, WRITEENABLE=0, IMEM_READ=0.
  - All decode outputs are 0 while in reset.
  - Reset asserted mid-fetch abandons the fetch; no partial IR update.
- Instruction format: OP[31:24], DEST[23:16], SRC1[15:8], SRC2/IMM[7:0].
  - Register fields use the low REG_AW bits.
  - For j/beq, DEST is a signed 8-bit word offset.
- Opcodes: 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or, 6 j, 7 beq. 8-255 are illegal.
- State machine (2 states, registered):
  - FETCH: IMEM_READ=1, IMEM_ADDR=PC, WRITEENABLE=0.
    - Stays in FETCH while IMEM_BUSYWAIT=1.
    - On the first rising edge with BUSYWAIT=0: IR<=IMEM_DATA, go to EXEC.
    - IMEM_READ also deasserts for the first cycle out of reset (RESET must be 1 at that edge).
  - EXEC (exactly 1 cycle): IMEM_READ=0. Decode outputs are combinational from IR.
    - WRITEENABLE=1 for ops 0-5 only.
    - IMM_SEL=1 for loadi only.
    - NEG_SEL=1 for sub and beq.
    - ALUOP: loadi/mov=000, add/sub/beq=001, and=010, or=011, j=000.
    - At the closing edge the PC updates and the state returns to FETCH.
- PC update at the end of EXEC:
  - j: PC <= PC+4+(sext(DEST)<<2).
  - beq: same target if ZERO=1, else PC+4.
  - All other ops: PC+4.
  - Arithmetic is modulo 2^PC_WIDTH, so wrap-around is silent (e.g. PC=0xFFFFFFFC, +4 gives 0).
- Illegal opcode: no write and PC+4. ILLEGAL=1 during that EXEC cycle only.
- Latency: minimum 2 cycles per instruction (1 FETCH + 1 EXEC), plus 1 cycle per BUSYWAIT cycle.
- Decode outputs are held stable from IR through FETCH; only WRITEENABLE gates writes.
- The register file writes at the EXEC-closing edge.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - opcode constants OP_LOADI..OP_BEQ
  - ALUOP encodings
  - instruction field bit positions
  - state encoding ST_FETCH/ST_EXEC
  - ALU and the top-level CPU reuse these.
- One natural sub-module: instr_decoder, purely combinational, IR -> READREG1/2, WRITEREG, IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, write-class, branch-class, ILLEGAL-class.
- PC, IR and the FSM stay in the parent.

Test Plan:
- Reset: hold RESET=0 for 3 cycles, release -> PC=0, IMEM_READ=1 on the next cycle, WRITEENABLE=0 throughout reset; assert RESET=0 mid-FETCH -> IMEM_READ drops immediately.
- Fetch with wait: IMEM_DATA=0x00030038 (loadi r3,56), BUSYWAIT high 3 cycles -> IR latched on the 4th edge; EXEC shows WRITEREG=3, IMMEDIATE=56, IMM_SEL=1, WRITEENABLE=1 for one cycle; next IMEM_ADDR=4.
- Arithmetic: 0x03010205 (sub r1,r2,r5) -> READREG1=2, READREG2=5, WRITEREG=1, ALUOP=001, NEG_SEL=1, PC+4.
- Branch: at PC=0x10, beq 0x07FE0102 with ZERO=1 -> next PC=0x10+4-8=0x0C; with ZERO=0 -> 0x14. j with offset 0x7F from PC=0 -> 0x200.
- Illegal: opcode 0xFF -> ILLEGAL one-cycle pulse, WRITEENABLE=0, PC+4.
- Wrap: RESET_PC=0xFFFFFFFC, execute add -> next IMEM_ADDR=0x00000000.
